// File: rtl/mcp_controller_p.sv
// mcp_controller_p: multicycle MIPS control unit with memory-ready stalls, bounded-wait timeout,
// sticky error state and retired-instruction counter. Define MCP_BNE_EN to enable the bne instruction.
module mcp_controller_p #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             error,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_BNE    = 4'd12,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_store;
    logic              wait_state;
    logic              timeout;
    logic              pcwrite;
    logic [1:0]        aluop;

    assign wait_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    assign timeout    = wait_state && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    // The lw/sw choice is captured in DECODE so op is not needed again in MEMADR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
            instret   <= '0;
            is_store  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cur_state <= nxt_state;
            if (nxt_state != cur_state)
                wait_cnt <= '0;
            else if (wait_state && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (cur_state == S_DECODE)
                is_store <= (op == OP_SW);
            if ((nxt_state == S_FETCH) && (cur_state != S_FETCH))
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of inferred latches.
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH:  if (mem_ready) nxt_state = S_DECODE;
                      else if (timeout) nxt_state = S_ERROR;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYP:      nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BEQ;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
`ifdef MCP_BNE_EN
                    OP_BNE:       nxt_state = S_BNE;
`endif
                    default:      nxt_state = S_ERROR;
                endcase
            end
            S_MEMADR: nxt_state = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) nxt_state = S_MEMWB;
                      else if (timeout) nxt_state = S_ERROR;
            S_MEMWR:  if (mem_ready) nxt_state = S_FETCH;
                      else if (timeout) nxt_state = S_ERROR;
            S_EXEC:   nxt_state = S_ALUWB;
            S_ADDIEX: nxt_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_BNE, S_JUMP: nxt_state = S_FETCH;
            S_ERROR:  nxt_state = S_ERROR;
            default:  nxt_state = S_ERROR;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (cur_state)
            S_FETCH: begin
                irwrite = mem_ready;
                pcwrite = mem_ready;
                alusrcb = 2'b01;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BEQ, S_BNE: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ERROR drives an all-zero control word, including the ALU operation.
    always_comb begin
        alucontrol = 3'b010;
        if (cur_state == S_ERROR)
            alucontrol = 3'b000;
        else if (aluop == 2'b01)
            alucontrol = 3'b110;
        else if (aluop == 2'b10) begin
            case (funct)
                6'b100010: alucontrol = 3'b110;
                6'b100100: alucontrol = 3'b000;
                6'b100101: alucontrol = 3'b001;
                6'b101010: alucontrol = 3'b111;
                default:   alucontrol = 3'b010;
            endcase
        end
    end

    assign pcen  = pcwrite | ((cur_state == S_BEQ) & zero) | ((cur_state == S_BNE) & ~zero);
    assign error = (cur_state == S_ERROR);
    assign state = cur_state;

endmodule

// File: tb/tb_mcp_controller_p.sv
// Testbench for mcp_controller_p: directed scenarios plus randomized traffic against an
// instruction-level reference model (per-opcode state sequences, stall budget, retire count).
`timescale 1ns/1ps
module tb_mcp_controller_p;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 4;
    localparam int CNT_W    = 4;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [5:0]       op = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b1;
    logic             pcen, memwrite, irwrite, regwrite;
    logic             alusrca, iord, memtoreg, regdst;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alucontrol;
    logic             error;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;
    logic [14:0]      cw;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcp_controller_p #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .error(error), .instret(instret), .state(state)
    );

    assign cw = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                 alusrcb, pcsrc, alucontrol};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state = 0;
    int m_stall = 0;
    int m_ret   = 0;
    int m_plan[$];

    function automatic logic [2:0] exp_alu(input int aop, input logic [5:0] f);
        if (aop == 0) return 3'b010;
        if (aop == 1) return 3'b110;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [14:0] exp_cw(input int s, input logic mr, input logic z, input logic [5:0] f);
        logic pw, pe, mw, irw, rw, asa, io, mtr, rd;
        logic [1:0] asb, pcs;
        int aop;
        {pw, mw, irw, rw, asa, io, mtr, rd} = '0;
        asb = 2'd0; pcs = 2'd0; aop = 0;
        if (s == 15) return 15'd0;
        case (s)
            0:     begin irw = mr; pw = mr; asb = 2'd1; end
            1:     asb = 2'd3;
            2, 9:  begin asa = 1'b1; asb = 2'd2; end
            3:     io = 1'b1;
            4:     begin mtr = 1'b1; rw = 1'b1; end
            5:     begin io = 1'b1; mw = 1'b1; end
            6:     begin asa = 1'b1; aop = 2; end
            7:     begin rd = 1'b1; rw = 1'b1; end
            10:    rw = 1'b1;
            8, 12: begin asa = 1'b1; aop = 1; pcs = 2'd1; end
            11:    begin pcs = 2'd2; pw = 1'b1; end
            default: ;
        endcase
        pe = pw | ((s == 8) && z) | ((s == 12) && !z);
        return {pe, mw, irw, rw, asa, io, mtr, rd, asb, pcs, exp_alu(aop, f)};
    endfunction

    // Advance one instruction step: memory phases wait on mem_ready within the stall budget,
    // DECODE loads the state sequence of the opcode, and an exhausted sequence retires.
    task automatic model_advance();
        if (m_state == 15) return;
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
            if (m_stall == MAX_WAIT - 1) begin
                m_state = 15;
                m_plan.delete();
            end else m_stall++;
            return;
        end
        m_stall = 0;
        if (m_state == 0) begin
            m_state = 1;
            return;
        end
        if (m_state == 1) begin
            case (op)
                OP_LW:   m_plan = '{2, 3, 4};
                OP_SW:   m_plan = '{2, 5};
                OP_RTYP: m_plan = '{6, 7};
                OP_BEQ:  m_plan = '{8};
                OP_ADDI: m_plan = '{9, 10};
                OP_J:    m_plan = '{11};
`ifdef MCP_BNE_EN
                OP_BNE:  m_plan = '{12};
`endif
                default: begin
                    m_state = 15;
                    return;
                end
            endcase
        end
        if (m_plan.size() == 0) begin
            m_state = 0;
            m_ret = (m_ret + 1) % (1 << CNT_W);
        end else m_state = m_plan.pop_front();
    endtask

    always begin
        @(negedge clk);
        if (!reset_n) begin
            m_state = 0;
            m_stall = 0;
            m_ret   = 0;
            m_plan.delete();
        end
        check("model_state", state, m_state);
        check("model_cw", cw, exp_cw(m_state, mem_ready, zero, funct));
        check("model_error", error, (m_state == 15));
        check("model_instret", instret, m_ret);
        if (reset_n) model_advance();
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr,
                       input int exp_state, input string name);
        @(posedge clk); #1;
        op = o; funct = f; zero = z; mem_ready = mr;
        @(negedge clk); #1;
        check(name, state, exp_state);
    endtask

    task automatic release_rst();
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("rel_state", state, 0);
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 15))
            0, 1, 2: return OP_LW;
            3, 4:    return OP_SW;
            5, 6, 7: return OP_RTYP;
            8, 9:    return OP_BEQ;
            10, 11:  return OP_ADDI;
            12, 14:  return OP_J;
            13:      return OP_BNE;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 6))
            0:       return 6'b100000;
            1:       return 6'b100010;
            2:       return 6'b100100;
            3:       return 6'b100101;
            4:       return 6'b101010;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        burst = 0;
        op = OP_LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_instret", instret, 0);
        check("rst_error", error, 0);
        check("rst_cw", cw, 15'h5022);
        release_rst();
        check("fetch_cw", cw, 15'h5022);

        // lw, no stalls
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 1, "lw_decode");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 2, "lw_memadr");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 3, "lw_memrd");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4, "lw_memwb");
        check("lw_memwb_wr", {regwrite, memtoreg}, 2'b11);
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 0, "lw_fetch");
        check("lw_instret", instret, 1);

        // R-type slt
        cyc(OP_RTYP, 6'b101010, 1'b0, 1'b1, 1, "r_decode");
        cyc(OP_RTYP, 6'b101010, 1'b0, 1'b1, 6, "r_exec");
        check("r_alucontrol", alucontrol, 3'b111);
        cyc(OP_RTYP, 6'b101010, 1'b0, 1'b1, 7, "r_aluwb");
        check("r_regdst", regdst, 1);
        cyc(OP_RTYP, 6'b101010, 1'b0, 1'b1, 0, "r_fetch");

        // beq taken and not taken
        cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, 1, "beq1_decode");
        cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, 8, "beq1_state");
        check("beq1_pcen_pcsrc", {pcen, pcsrc}, 3'b101);
        cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, 0, "beq1_fetch");
        cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, 1, "beq0_decode");
        cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, 8, "beq0_state");
        check("beq0_pcen", pcen, 0);
        cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, 0, "beq0_fetch");

        // lw with three stall cycles in MEMRD: 8 cycles total
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 1, "lws_decode");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 2, "lws_memadr");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 3, "lws_stall1");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 3, "lws_stall2");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 3, "lws_stall3");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 3, "lws_memrd");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4, "lws_memwb");

        // FETCH timeout after MAX_WAIT cycles of mem_ready low
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 0, "to_fetch0");
        check("lws_error", error, 0);
        check("lws_instret", instret, 5);
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 0, "to_fetch1");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 0, "to_fetch2");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 0, "to_fetch3");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 15, "to_error");
        check("to_error_flag", error, 1);
        check("to_cw_zero", cw, 15'h0000);
        check("to_instret", instret, 5);
        cyc(OP_LW, 6'd0, 1'b1, 1'b1, 15, "to_sticky");
        check("to_sticky_flag", error, 1);

        // illegal opcode
        reset_n = 1'b0;
        #1;
        check("rst2_state", state, 0);
        check("rst2_error", error, 0);
        op = 6'b111111; mem_ready = 1'b1;
        release_rst();
        cyc(6'b111111, 6'd0, 1'b0, 1'b1, 1, "ill_decode");
        cyc(6'b111111, 6'd0, 1'b0, 1'b1, 15, "ill_error");
        check("ill_instret", instret, 0);

        // reset mid-stall takes effect before the next clock edge
        reset_n = 1'b0;
        op = OP_J;
        release_rst();
        cyc(OP_J, 6'd0, 1'b0, 1'b1, 1, "j_decode");
        cyc(OP_J, 6'd0, 1'b0, 1'b1, 11, "j_state");
        check("j_pcen_pcsrc", {pcen, pcsrc}, 3'b110);
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 0, "j_fetch");
        check("j_instret", instret, 1);
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 1, "ms_decode");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 2, "ms_memadr");
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 3, "ms_stall");
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("ms_rst_state", state, 0);
        check("ms_rst_instret", instret, 0);
        check("ms_rst_error", error, 0);
        check("ms_rst_pcen_irwrite", {pcen, irwrite}, 2'b11);

        // bne with zero=0
        op = OP_BNE; zero = 1'b0;
        release_rst();
        cyc(OP_BNE, 6'd0, 1'b0, 1'b1, 1, "bne_decode");
`ifdef MCP_BNE_EN
        cyc(OP_BNE, 6'd0, 1'b0, 1'b1, 12, "bne_state");
        check("bne_pcen_pcsrc", {pcen, pcsrc}, 3'b101);
        cyc(OP_BNE, 6'd0, 1'b0, 1'b1, 0, "bne_fetch");
        check("bne_instret", instret, 1);
`else
        cyc(OP_BNE, 6'd0, 1'b0, 1'b1, 15, "bne_illegal");
        check("bne_error", error, 1);
`endif

        // 2^CNT_W + 1 jumps wrap the retire counter to 1
        reset_n = 1'b0;
        op = OP_J;
        release_rst();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            cyc(OP_J, 6'd0, 1'b0, 1'b1, 1, "wrap_decode");
            cyc(OP_J, 6'd0, 1'b0, 1'b1, 11, "wrap_jump");
            cyc(OP_J, 6'd0, 1'b0, 1'b1, 0, "wrap_fetch");
        end
        check("wrap_instret", instret, 1);

        // randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 79) == 0) reset_n = 1'b0;
            op    = pick_op();
            funct = pick_funct();
            zero  = 1'($urandom_range(0, 1));
            if (burst > 0) begin
                mem_ready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 149) == 0) begin
                burst = $urandom_range(3, 6);
                mem_ready = 1'b0;
            end else mem_ready = ($urandom_range(0, 4) != 0);
        end
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
